ksa_pipe: RTL and testbench

- Parametrised, pipelined Kogge-Stone adder/subtractor with valid/ready handshakes on input and output.
- Successor to the combinational ksa block: adds configurable pipeline depth, a subtract mode, carry-out and signed-overflow flags, and backpressure.
- Sits in the multiplier datapath as the final carry-propagate adder, or as a standalone ALU adder.

---
 rtl/ksa_pipe.sv | 186 ++++++++++++++++++
 tb/tb_ksa_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ksa_pipe.sv
// ksa_pipe -- pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
//
// Computes {cout,sum} = a + b' + c0, where b' = sub ? ~b : b and c0 = sub ? 1 : cin.
// ovf is the two's-complement overflow flag: carry into the MSB xor carry out of it.
// STAGES register stages are spread over the log2(BITS) prefix levels; the last one
// is always the output register. A single global stall (out_valid && !out_ready)
// freezes every stage, so in_ready is simply its complement.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears every stage valid and the outputs
//   in_valid   operands a/b/cin/sub present
//   in_ready   pipe accepts operands this cycle (combinational from out_ready)
//   a, b       BITS-wide operands
//   cin        carry-in, ignored when sub=1
//   sub        0: a+b+cin, 1: a-b
//   out_valid  sum/cout/ovf hold a result
//   out_ready  downstream accepts the result
//   sum        result modulo 2^BITS
//   cout       carry out of the MSB (sub=1: 1 means no borrow)
//   ovf        signed overflow
module ksa_pipe #(
  parameter int BITS   = 16,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            cin,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] sum,
  output logic            cout,
  output logic            ovf
);

  localparam int LEVELS = $clog2(BITS);
  // Registers available for placement between prefix levels (the output register is separate).
  localparam int INNER  = STAGES - 1;

  if (BITS < 2 || BITS > 64) begin : g_bad_bits
    $error("ksa_pipe: BITS=%0d is outside 2..64", BITS);
  end
  if (STAGES < 1 || STAGES > LEVELS + 1) begin : g_bad_stages
    $error("ksa_pipe: STAGES=%0d is outside 1..%0d", STAGES, LEVELS + 1);
  end

  logic stall_s;

  // Global stall: a result held at the output freezes every stage.
  always_comb begin
    stall_s  = out_valid & ~out_ready;
    in_ready = ~stall_s;
  end

  logic [BITS-1:0] bx_s;
  logic [BITS-1:0] p0_s;
  logic [BITS-1:0] g0_s;
  logic            c0_s;

  // Operand conditioning and bitwise generate/propagate. The carry-in is folded into
  // the bit-0 generate so that every prefix result G[i] is directly the carry into bit i+1.
  always_comb begin
    bx_s    = sub ? ~b : b;
    c0_s    = sub ? 1'b1 : cin;
    p0_s    = a ^ bx_s;
    g0_s    = a & bx_s;
    g0_s[0] = g0_s[0] | (p0_s[0] & c0_s);
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int SPAN   = 1 << k;
    // Spread INNER registers evenly: level k gets one when the running share ticks over.
    localparam bit IS_REG = (((k + 1) * INNER) / LEVELS) > ((k * INNER) / LEVELS);

    logic [BITS-1:0] gi_s, pi_s, pb_s;
    logic            ci_s, vi_s;
    logic [BITS-1:0] gn_s, pn_s;
    logic [BITS-1:0] go_s, po_s, pbo_s;
    logic            co_s, vo_s;

    if (k == 0) begin : g_src
      assign gi_s = g0_s;
      assign pi_s = p0_s;
      assign pb_s = p0_s;
      assign ci_s = c0_s;
      assign vi_s = in_valid;
    end else begin : g_src
      assign gi_s = g_lvl[k-1].go_s;
      assign pi_s = g_lvl[k-1].po_s;
      assign pb_s = g_lvl[k-1].pbo_s;
      assign ci_s = g_lvl[k-1].co_s;
      assign vi_s = g_lvl[k-1].vo_s;
    end

    // Prefix combine at distance SPAN; the lowest SPAN positions are already final.
    always_comb begin
      gn_s = gi_s;
      pn_s = pi_s;
      for (int i = SPAN; i < BITS; i++) begin
        gn_s[i] = gi_s[i] | (pi_s[i] & gi_s[i-SPAN]);
        pn_s[i] = pi_s[i] & pi_s[i-SPAN];
      end
    end

    if (IS_REG) begin : g_reg
      logic [BITS-1:0] g_r, p_r, pb_r;
      logic            c_r, v_r;

      // Pipeline register after this level; data and valid advance together unless stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          g_r  <= '0;
          p_r  <= '0;
          pb_r <= '0;
          c_r  <= 1'b0;
          v_r  <= 1'b0;
        end else if (!stall_s) begin
          g_r  <= gn_s;
          p_r  <= pn_s;
          pb_r <= pb_s;
          c_r  <= ci_s;
          v_r  <= vi_s;
        end
      end

      assign go_s  = g_r;
      assign po_s  = p_r;
      assign pbo_s = pb_r;
      assign co_s  = c_r;
      assign vo_s  = v_r;
    end else begin : g_wire
      assign go_s  = gn_s;
      assign po_s  = pn_s;
      assign pbo_s = pb_s;
      assign co_s  = ci_s;
      assign vo_s  = vi_s;
    end
  end

  logic [BITS-1:0] gf_s, pbf_s;
  logic            cf_s, vf_s;
  logic            unused_pf_s;
  logic [BITS-1:0] sum_s;
  logic            cout_s, ovf_s;

  assign gf_s        = g_lvl[LEVELS-1].go_s;
  assign pbf_s       = g_lvl[LEVELS-1].pbo_s;
  assign cf_s        = g_lvl[LEVELS-1].co_s;
  assign vf_s        = g_lvl[LEVELS-1].vo_s;
  // Group propagate is not needed after the last prefix level.
  assign unused_pf_s = ^g_lvl[LEVELS-1].po_s;

  // Sum and flags: carry into bit i is G[i-1] (c0 for bit 0).
  always_comb begin
    sum_s  = pbf_s ^ {gf_s[BITS-2:0], cf_s};
    cout_s = gf_s[BITS-1];
    ovf_s  = gf_s[BITS-1] ^ gf_s[BITS-2];
  end

  // Output register: holds while stalled, zeroes its data when it loads a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (!stall_s) begin
      out_valid <= vf_s;
      if (vf_s) begin
        sum  <= sum_s;
        cout <= cout_s;
        ovf  <= ovf_s;
      end else begin
        sum  <= '0;
        cout <= 1'b0;
        ovf  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ksa_pipe.sv
// Self-checking bench for ksa_pipe. Expected {ovf,cout,sum} values are pushed to a
// per-instance queue when an operand set is accepted and popped when the result drains.
module tb_ksa_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst16_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   sw_done = 0;
  bit   dir5_done = 1'b0;
  bit   dir16_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] exp;
    int           acc;
  } item_t;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain wide addition, overflow from operand/result sign bits.
  function automatic logic [65:0] model(input int w, input logic [63:0] xa, input logic [63:0] xb,
                                        input logic xcin, input logic xsub);
    logic [64:0] mask, opb, full;
    logic [63:0] s;
    logic        c0, co, ov;
    mask = (65'd1 << w) - 65'd1;
    opb  = xsub ? (~{1'b0, xb} & mask) : {1'b0, xb};
    c0   = xsub ? 1'b1 : xcin;
    full = {1'b0, xa} + opb + {64'd0, c0};
    s    = full[63:0] & mask[63:0];
    co   = full[w];
    ov   = (xa[w-1] == opb[w-1]) && (full[w-1] != xa[w-1]);
    return {ov, co, s};
  endfunction

  // ---------------- BITS=5, STAGES=2: directed cases ----------------
  logic       v5_in, r5_in, cin5, sub5, v5_out, rdy5_out, cout5, ovf5;
  logic [4:0] a5, b5, sum5;
  item_t      q5[$];

  ksa_pipe #(.BITS(5), .STAGES(2)) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5_in), .in_ready(r5_in), .a(a5), .b(b5),
    .cin(cin5), .sub(sub5), .out_valid(v5_out), .out_ready(rdy5_out), .sum(sum5),
    .cout(cout5), .ovf(ovf5)
  );

  task automatic send5(input logic [4:0] xa, input logic [4:0] xb, input logic xcin,
                       input logic xsub, input logic [127:0] exp);
    item_t it;
    bit    ok;
    @(posedge clk); #1;
    v5_in = 1'b1; a5 = xa; b5 = xb; cin5 = xcin; sub5 = xsub;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (r5_in) begin
        it.exp = exp;
        it.acc = cyc + 1;
        q5.push_back(it);
        ok = 1'b1;
      end
    end
    if (!ok) check_val("u5 accept", 128'(ok), 128'(1));
  endtask

  always @(negedge clk) begin : mon5
    item_t it;
    if (v5_out && rdy5_out) begin
      check_val("u5 pending", 128'(q5.size() != 0), 128'(1));
      if (q5.size() != 0) begin
        it = q5.pop_front();
        check_val("u5 result", 128'({ovf5, cout5, 64'(sum5)}), it.exp);
        check_val("u5 latency", 128'(cyc + 1 - it.acc), 128'(2));
      end
    end else if (rst_n) begin
      check_val("u5 idle zero", 128'({ovf5, cout5, sum5}), 128'(0));
    end
  end

  initial begin : dir5
    v5_in = 1'b0; a5 = '0; b5 = '0; cin5 = 1'b0; sub5 = 1'b0; rdy5_out = 1'b1;
    rst_n = 1'b0;
    #12;
    check_val("u5 reset state", 128'({v5_out, ovf5, cout5, sum5}), 128'(0));
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    send5(5'd13, 5'd12, 1'b0, 1'b0, 128'({1'b1, 1'b0, 64'd25}));
    send5(5'd31, 5'd1,  1'b1, 1'b0, 128'({1'b0, 1'b1, 64'd1}));
    send5(5'd5,  5'd9,  1'b1, 1'b1, 128'({1'b0, 1'b0, 64'd28}));
    @(posedge clk); #1 v5_in = 1'b0;
    repeat (8) @(posedge clk);
    check_val("u5 drained", 128'(q5.size()), 128'(0));
    dir5_done = 1'b1;
  end

  // ---------------- BITS=16, STAGES=5: stream, backpressure, reset ----------------
  logic        v16_in, r16_in, cin16, sub16, v16_out, rdy16_out, cout16, ovf16;
  logic [15:0] a16, b16, sum16;
  item_t       q16[$];
  bit          lat16_en;

  ksa_pipe #(.BITS(16), .STAGES(5)) u16 (
    .clk(clk), .rst_n(rst16_n), .in_valid(v16_in), .in_ready(r16_in), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(v16_out), .out_ready(rdy16_out), .sum(sum16),
    .cout(cout16), .ovf(ovf16)
  );

  task automatic send16(input logic [15:0] xa, input logic [15:0] xb, input logic xcin,
                        input logic xsub);
    item_t it;
    bit    ok;
    @(posedge clk); #1;
    v16_in = 1'b1; a16 = xa; b16 = xb; cin16 = xcin; sub16 = xsub;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (r16_in) begin
        it.exp = 128'(model(16, 64'(xa), 64'(xb), xcin, xsub));
        it.acc = cyc + 1;
        q16.push_back(it);
        ok = 1'b1;
      end
    end
    if (!ok) check_val("u16 accept", 128'(ok), 128'(1));
  endtask

  task automatic send16_rand();
    send16(16'($urandom()), 16'($urandom()), 1'($urandom()), 1'($urandom()));
  endtask

  task automatic idle16();
    @(posedge clk); #1 v16_in = 1'b0;
  endtask

  always @(negedge clk) begin : mon16
    item_t it;
    if (rst16_n) check_val("u16 in_ready", 128'(r16_in), 128'(!(v16_out && !rdy16_out)));
    if (v16_out && rdy16_out) begin
      check_val("u16 pending", 128'(q16.size() != 0), 128'(1));
      if (q16.size() != 0) begin
        it = q16.pop_front();
        check_val("u16 result", 128'({ovf16, cout16, 64'(sum16)}), it.exp);
        if (lat16_en) check_val("u16 latency", 128'(cyc + 1 - it.acc), 128'(5));
      end
    end
  end

  initial begin : dir16
    bit ok;
    v16_in = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; rdy16_out = 1'b1;
    lat16_en = 1'b1;
    rst16_n = 1'b0;
    #12;
    check_val("u16 reset state", 128'({v16_out, ovf16, cout16, sum16}), 128'(0));
    repeat (3) @(posedge clk);
    #3 rst16_n = 1'b1;

    // Back-to-back stream.
    for (int i = 0; i < 100; i++) send16_rand();
    idle16();
    repeat (10) @(posedge clk);
    check_val("u16 stream drained", 128'(q16.size()), 128'(0));

    // Backpressure: full pipe, output held for four edges.
    lat16_en = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send16_rand();
        idle16();
      end
      begin
        logic [18:0] snap;
        repeat (8) @(posedge clk);
        #1 rdy16_out = 1'b0;
        @(negedge clk);
        snap = {v16_out, ovf16, cout16, sum16};
        check_val("u16 stall valid", 128'(v16_out), 128'(1));
        check_val("u16 stall in_ready", 128'(r16_in), 128'(0));
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check_val("u16 stall in_ready", 128'(r16_in), 128'(0));
          check_val("u16 stall hold", 128'({v16_out, ovf16, cout16, sum16}), 128'(snap));
        end
        @(posedge clk); #1 rdy16_out = 1'b1;
      end
    join
    repeat (12) @(posedge clk);
    check_val("u16 bp drained", 128'(q16.size()), 128'(0));
    lat16_en = 1'b1;

    // Asynchronous reset while two results are in flight, one already at the output.
    send16_rand();
    send16_rand();
    idle16();
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = v16_out;
    end
    check_val("u16 valid before reset", 128'(ok), 128'(1));
    #2 rst16_n = 1'b0;
    #1;
    check_val("u16 async reset", 128'({v16_out, ovf16, cout16, sum16}), 128'(0));
    q16.delete();
    @(posedge clk);
    #3 rst16_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("u16 quiet after reset", 128'(v16_out), 128'(0));
    end

    // Recovery after reset.
    for (int i = 0; i < 10; i++) send16_rand();
    idle16();
    repeat (10) @(posedge clk);
    check_val("u16 final drained", 128'(q16.size()), 128'(0));
    dir16_done = 1'b1;
  end

  // ---------------- Parameter sweep: BITS x {min, max} STAGES ----------------
  for (genvar gi = 0; gi < 5; gi++) begin : g_sw
    for (genvar gs = 0; gs < 2; gs++) begin : g_st
      localparam int W = (gi == 0) ? 2 : (gi == 1) ? 5 : (gi == 2) ? 8 : (gi == 3) ? 33 : 64;
      localparam int S = (gs == 0) ? 1 : $clog2(W) + 1;
      localparam int N = (W <= 8) ? (1 << (2 * W)) : 3000;

      logic [W-1:0] a_s, b_s, sum_s;
      logic         cin_s, sub_s, iv_s, ir_s, ov_s, cout_s, ovf_s;
      item_t        q[$];
      string        tag_s;

      ksa_pipe #(.BITS(W), .STAGES(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir_s), .a(a_s), .b(b_s),
        .cin(cin_s), .sub(sub_s), .out_valid(ov_s), .out_ready(1'b1), .sum(sum_s),
        .cout(cout_s), .ovf(ovf_s)
      );

      always @(negedge clk) begin : mon
        item_t it;
        if (ov_s) begin
          check_val({tag_s, " pending"}, 128'(q.size() != 0), 128'(1));
          if (q.size() != 0) begin
            it = q.pop_front();
            check_val({tag_s, " result"}, 128'({ovf_s, cout_s, 64'(sum_s)}), it.exp);
            check_val({tag_s, " latency"}, 128'(cyc + 1 - it.acc), 128'(S));
          end
        end
      end

      initial begin : drv
        logic [63:0] ra, rb;
        item_t       it;
        bit          ok;
        tag_s = $sformatf("sw B%0d S%0d", W, S);
        iv_s = 1'b0; a_s = '0; b_s = '0; cin_s = 1'b0; sub_s = 1'b0;
        wait (rst_n === 1'b1);
        for (int n = 0; n < N; n++) begin
          if (W <= 8) begin
            ra = 64'(n);
            rb = 64'(n >> W);
          end else begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
          end
          @(posedge clk); #1;
          iv_s = 1'b1; a_s = ra[W-1:0]; b_s = rb[W-1:0];
          cin_s = 1'($urandom()); sub_s = 1'($urandom());
          ok = 1'b0;
          for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (ir_s) begin
              it.exp = 128'(model(W, 64'(a_s), 64'(b_s), cin_s, sub_s));
              it.acc = cyc + 1;
              q.push_back(it);
              ok = 1'b1;
            end
          end
          if (!ok) check_val({tag_s, " accept"}, 128'(ok), 128'(1));
        end
        @(posedge clk); #1 iv_s = 1'b0;
        repeat (S + 3) @(posedge clk);
        check_val({tag_s, " drained"}, 128'(q.size()), 128'(0));
        sw_done++;
      end
    end
  end

  // ---------------- Completion ----------------
  initial begin : finisher
    bit all_done;
    fork
      wait (dir5_done && dir16_done && (sw_done == 10));
      #950000;
    join_any
    disable fork;
    all_done = dir5_done && dir16_done && (sw_done == 10);
    check_val("run complete", 128'(all_done), 128'(1));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
